// File: rtl/rf_wr_arbiter_if.sv
// Bus bundle between the writeback sources and the register-file write arbiter.
// The master side belongs to the requesters, the slave side to the arbiter.
interface rf_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 3,
  parameter int DW   = 16,
  parameter int CW   = 8
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               hold;

  logic [NREQ-1:0]    gnt;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic               r0_drop;
  logic [CW-1:0]      conflict_cnt;

  modport master (
    output req, req_addr, req_data, hold,
    input  gnt, rf_we, rf_waddr, rf_wdata, r0_drop, conflict_cnt
  );

  modport slave (
    input  req, req_addr, req_data, hold,
    output gnt, rf_we, rf_waddr, rf_wdata, r0_drop, conflict_cnt
  );

endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port: one registered
// write per cycle, R0 writes suppressed, contention counted.
module rf_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 3,
  parameter int DW   = 16,
  parameter int CW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  rf_wr_arbiter_if.slave bus
);

  localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic            r0_drop_q, r0_drop_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] eligible;
  logic            any_elig;
  logic            multi_elig;
  logic            fire;
  logic [IW-1:0]   winner;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // A requester granted this cycle is still showing its old req level; mask it.
  always_comb begin : eligibility
    eligible   = bus.req & ~gnt_q;
    any_elig   = |eligible;
    multi_elig = (eligible & (eligible - NREQ'(1))) != '0;
    fire       = !bus.hold && any_elig;
  end

  // Search starts one past the previous winner and wraps.
  always_comb begin : pick_winner
    int   idx;
    logic found;
    winner = last_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && eligible[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin : winner_slice
    win_addr = bus.req_addr[int'(winner)*AW +: AW];
    win_data = bus.req_data[int'(winner)*DW +: DW];
  end

  always_comb begin : next_state
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = IDLE;
    gnt_d      = '0;
    rf_we_d    = 1'b0;
    r0_drop_d  = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    last_d     = last_q;
    cnt_d      = cnt_q;

    // GRANT is a one-cycle state; both states re-arbitrate on every edge.
    unique case (state_q)
      IDLE:    state_d = fire ? GRANT : IDLE;
      GRANT:   state_d = fire ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase

    if (fire) begin
      gnt_d      = NREQ'(1) << winner;
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
      rf_we_d    = (win_addr != '0);
      r0_drop_d  = (win_addr == '0);
      last_d     = winner;
    end

    if (!bus.hold && multi_elig && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      r0_drop_q  <= 1'b0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      r0_drop_q  <= r0_drop_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.r0_drop      = r0_drop_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: a behavioural model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_rf_wr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 3;
  localparam int DW   = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) bus ();

  rf_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            drop;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t exp_q[$];

  // Model state: who won last, who was granted in the previous cycle (-1 none).
  int            m_last  = NREQ - 1;
  int            m_prev  = -1;
  int            m_cnt   = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;

  always @(negedge rst) begin
    m_last  = NREQ - 1;
    m_prev  = -1;
    m_cnt   = 0;
    m_waddr = '0;
    m_wdata = '0;
    exp_q.delete();
  end

  always @(posedge clk) begin : model
    exp_t e;
    int   n;
    int   w;
    int   i;
    if (rst) begin
      n = 0;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_last + k) % NREQ;
        if (bus.req[i] && i != m_prev) begin
          n = n + 1;
          if (w < 0) w = i;
        end
      end
      if (!bus.hold && n >= 2 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      e = '0;
      if (!bus.hold && w >= 0) begin
        m_waddr = bus.req_addr[w*AW +: AW];
        m_wdata = bus.req_data[w*DW +: DW];
        e.gnt   = NREQ'(1) << w;
        e.we    = (m_waddr != 0);
        e.drop  = (m_waddr == 0);
        m_last  = w;
        m_prev  = w;
      end else begin
        m_prev = -1;
      end
      e.waddr = m_waddr;
      e.wdata = m_wdata;
      e.cnt   = CW'(m_cnt);
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (rst && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {bus.gnt, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.r0_drop, bus.conflict_cnt};
      check("gnt/we/waddr/wdata/drop/cnt", 64'(a), 64'(e));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    bus.req  = '0;
    bus.hold = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt"},      64'(bus.gnt), 64'(0));
    check({tag, ".rf_we"},    64'(bus.rf_we), 64'(0));
    check({tag, ".rf_waddr"}, 64'(bus.rf_waddr), 64'(0));
    check({tag, ".rf_wdata"}, 64'(bus.rf_wdata), 64'(0));
    check({tag, ".r0_drop"},  64'(bus.r0_drop), 64'(0));
    check({tag, ".cnt"},      64'(bus.conflict_cnt), 64'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.hold     = 1'b0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst = 1'b1;

    // Single write to R5.
    @(negedge clk);
    set_slot(0, 3'd5, 16'hA5A5);
    bus.req = 3'b001;
    @(negedge clk);
    bus.req = 3'b000;
    repeat (2) @(negedge clk);

    // All three requesting, re-presenting new data after each grant.
    do_reset();
    set_slot(0, 3'd1, 16'h1111);
    set_slot(1, 3'd2, 16'h2222);
    set_slot(2, 3'd3, 16'h3333);
    bus.req = 3'b111;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (bus.gnt[i]) bus.req_data[i*DW +: DW] = DW'($urandom);
    end
    bus.req = '0;

    // Write to R0 from requester 1.
    do_reset();
    set_slot(1, 3'd0, 16'hFFFF);
    bus.req = 3'b010;
    @(negedge clk);
    bus.req = 3'b000;
    repeat (2) @(negedge clk);

    // Hold with two requesters pending, then release.
    do_reset();
    set_slot(0, 3'd4, 16'h4444);
    set_slot(1, 3'd6, 16'h6666);
    bus.hold = 1'b1;
    bus.req  = 3'b011;
    repeat (4) @(negedge clk);
    bus.hold = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.gnt;
    end
    bus.req = '0;

    // Asynchronous reset in the middle of a grant cycle.
    do_reset();
    set_slot(0, 3'd7, 16'h1234);
    bus.req = 3'b001;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    set_slot(1, 3'd1, 16'hBEEF);
    set_slot(2, 3'd2, 16'hCAFE);
    bus.req = 3'b110;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 check("first_after_reset.gnt", 64'(bus.gnt), 64'(3'b010));
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);

    // Long contention to drive the counter into saturation.
    do_reset();
    set_slot(0, 3'd1, 16'h0001);
    set_slot(1, 3'd2, 16'h0002);
    set_slot(2, 3'd3, 16'h0003);
    bus.req = 3'b111;
    repeat (300) @(negedge clk);
    check("cnt_saturated", 64'(bus.conflict_cnt), 64'(CMAX));
    repeat (5) @(negedge clk);
    check("cnt_held", 64'(bus.conflict_cnt), 64'(CMAX));
    bus.req = '0;

    // Randomised requesters honouring the handshake, occasional withdraw and hold.
    do_reset();
    repeat (500) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.gnt[i] || !bus.req[i]) begin
          bus.req[i] = 1'($urandom_range(1));
          set_slot(i, AW'($urandom), DW'($urandom));
        end else if ($urandom_range(15) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      bus.hold = ($urandom_range(7) == 0);
    end
    bus.req  = '0;
    bus.hold = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 8 x 16-bit register file between NREQ writeback sources: ALU writeback, load unit and PC-link.
- Accepts per-requester write requests with a req/gnt handshake and issues exactly one registered write per cycle to the register file.
- Suppresses writes to R0.
- Sits between the execute/memory writeback sources and the register-file write-enable/address/data inputs.

Parameters:
- NREQ, 3, number of requesters (2..4).
- AW, 3, register address width (8 registers).
- DW, 16, data width.
- CW, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset: asserted when 0, released when 1.
- req  in  NREQ  per-requester write request, level.
- req_addr  in  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- hold  in  1  when 1, no new grant is issued (pipeline stall/halt).
- gnt  out  NREQ  one-hot grant pulse, registered.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  AW  register-file write address, registered.
- rf_wdata  out  DW  register-file write data, registered.
- r0_drop  out  1  pulse: the granted write targeted R0 and was suppressed.
- conflict_cnt  out  CW  saturating count of cycles with more than one eligible request.

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, r0_drop=0, conflict_cnt=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has highest priority first.
  - State = IDLE.
- FSM has two states, IDLE and GRANT:
  - IDLE: if hold=0 and any eligible req -> GRANT. Otherwise stay in IDLE.
  - GRANT: lasts exactly one cycle. Then re-evaluate using the IDLE rules, so back-to-back grants are allowed.
- Eligibility: req[i]=1 AND NOT (gnt[i]=1 in the current cycle).
  - A just-granted requester is masked for the one cycle it takes to drop req.
  - This prevents a double grant from a stale level.
- Winner selection, combinational, evaluated at edge t:
  - Search eligible requests starting at index (last+1) mod NREQ, wrapping.
  - First hit wins; last <= winner.
- Latency: for a winner sampled at edge t, the following are all valid in cycle t..t+1 (registered, one-cycle latency):
  - gnt[winner]=1.
  - rf_waddr and rf_wdata captured from the winner's slice.
  - rf_we=1 unless the captured address is 0.
- Handshake:
  - The requester keeps req, req_addr and req_data stable until it sees gnt[i]=1.
  - It may drop req or present a new request in the cycle after gnt.
  - Withdrawing req before grant is legal. Nothing is latched for that requester.
- R0 writes:
  - gnt is issued normally and rf_waddr/rf_wdata are still updated.
  - rf_we=0 and r0_drop=1 for that cycle.
- hold=1:
  - No grant. gnt=0, rf_we=0, r0_drop=0 next cycle.
  - last is unchanged and conflict_cnt is not incremented.
  - A grant already issued in the current cycle completes.
- Idle cycles: gnt=0, rf_we=0, r0_drop=0. rf_waddr and rf_wdata hold their last values.
- conflict_cnt increments by 1 on each edge where hold=0 and two or more requests are eligible. It saturates at 2^CW-1.
- Reset mid-grant: outputs clear immediately and asynchronously. After release the first grant follows priority from requester 0.
- Single requester continuously asserting req (re-presenting it after each grant): granted every other cycle because of eligibility masking. Other requesters fill the gap cycles.

Test Plan:
- Reset release, req=3'b001, addr0=5, data0=16'hA5A5 -> next cycle gnt=001, rf_we=1, rf_waddr=5, rf_wdata=A5A5. After req drops, rf_we=0.
- req=3'b111 held (each requester re-asserts after its grant), distinct addrs 1/2/3 -> grant order 0,1,2,0... with no requester granted twice while others wait. conflict_cnt increments on each contended edge.
- req1 with addr=0, data=16'hFFFF -> gnt=010, rf_we=0, r0_drop=1. Register file contents unchanged.
- hold=1 for 4 cycles with req=3'b011 -> gnt=0, rf_we=0 throughout and conflict_cnt unchanged. After hold=0, requester 0 is granted first, then requester 1.
- rst driven to 0 during a gnt/rf_we cycle -> all outputs 0 immediately without a clock edge. After release with req=3'b110, requester 1 wins first.
- Drive 300 contended cycles with CW=8 -> conflict_cnt saturates at 255 and holds.
